// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if
//   Bundles the result-producer side and the register-file write side of the
//   write-back stage.
//
//   Handshake semantics (valid/ready):
//     ALU path : alu_valid has no ready; a result is taken every cycle it is
//                asserted.
//     LL path  : a transfer happens at a posedge where ll_valid && ll_ready.
//                ll_ready depends only on registered FIFO state, never on
//                ll_valid. The producer keeps ll_dest/ll_data stable while
//                ll_valid is high and ll_ready is low.
//     RF write : regWrite/regDest/writeData are registered. They change only
//                on posedge, so the register file can write on negedge.
//
//   Modports:
//     master : the write-back unit (consumes results, drives the register file)
//     slave  : the environment (producers, register file, issue stage)
interface regfile_writeback_if #(
  parameter int WIDTH = 32
);
  logic             alu_valid;
  logic [4:0]       alu_dest;
  logic [WIDTH-1:0] alu_data;
  logic             ll_valid;
  logic             ll_ready;
  logic [4:0]       ll_dest;
  logic [WIDTH-1:0] ll_data;
  logic             regWrite;
  logic [4:0]       regDest;
  logic [WIDTH-1:0] writeData;
  logic [31:0]      pending_mask;
  logic             hazard_err;

  modport master (
    input  alu_valid, alu_dest, alu_data,
    input  ll_valid, ll_dest, ll_data,
    output ll_ready,
    output regWrite, regDest, writeData,
    output pending_mask, hazard_err
  );

  modport slave (
    output alu_valid, alu_dest, alu_data,
    output ll_valid, ll_dest, ll_data,
    input  ll_ready,
    input  regWrite, regDest, writeData,
    input  pending_mask, hazard_err
  );
endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback
//   Write-back initiator for the 32x32 register file. It merges single-cycle
//   ALU results and long-latency results into one registered write port.
//   ALU results always win the port. Long-latency results wait in a DEPTH-entry
//   FIFO. A pending-destination mask is published so the issue stage can stall.
//
//   Ports:
//     clock    : system clock, posedge
//     reset_n  : asynchronous active-low reset
//     wb       : regfile_writeback_if.master, which carries:
//                alu_valid/alu_dest/alu_data   ALU result, no backpressure
//                ll_valid/ll_ready/ll_dest/ll_data  long-latency result handshake
//                regWrite/regDest/writeData     registered register-file write port
//                pending_mask                   destinations queued or in the output register
//                hazard_err                     ALU write to a pending destination
//
//   Parameters: DEPTH (power of 2, >= 2), WIDTH (data width).
//
//   Optional feature (macro WB_BYPASS_EN):
//     When defined, a long-latency result that arrives while the ALU is idle and
//     the FIFO is empty loads the output register directly, with one-cycle latency.
//     When undefined, every long-latency result passes through the FIFO.
module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic clock,
  input  logic reset_n,
  regfile_writeback_if.master wb
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one extra wrap bit. This tells full apart from empty.
  logic [PW-1:0]    rdPtr;
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    count;
  logic [4:0]       destMem [DEPTH];
  logic [WIDTH-1:0] dataMem [DEPTH];

  logic        full;
  logic        empty;
  logic        accept;
  logic        popFifo;
  logic        pushFifo;
  logic        bypassTake;
  logic [31:0] pendingMask;

  assign empty = (rdPtr == wrPtr);
  assign full  = (rdPtr[AW] != wrPtr[AW]) && (rdPtr[AW-1:0] == wrPtr[AW-1:0]);
  assign count = wrPtr - rdPtr;

  assign wb.ll_ready = !full;
  assign accept      = wb.ll_valid && !full;

  // The FIFO drains only on cycles where the ALU does not hold the port.
  assign popFifo = !wb.alu_valid && !empty;

`ifdef WB_BYPASS_EN
  assign bypassTake = !wb.alu_valid && empty && accept && (wb.ll_dest != 5'd0);
`else
  assign bypassTake = 1'b0;
`endif

  // A handshake to x0 completes, but nothing is stored.
  assign pushFifo = accept && (wb.ll_dest != 5'd0) && !bypassTake;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
    end else begin
      if (pushFifo) wrPtr <= wrPtr + PW'(1);
      if (popFifo)  rdPtr <= rdPtr + PW'(1);
    end
  end

  // The storage has no reset. Slots are only read while the pointers mark them valid.
  always_ff @(posedge clock) begin
    if (pushFifo) begin
      destMem[wrPtr[AW-1:0]] <= wb.ll_dest;
      dataMem[wrPtr[AW-1:0]] <= wb.ll_data;
    end
  end

  // Output register. An ALU result to x0 still claims the port for that cycle,
  // but nothing is written. regDest and writeData hold on idle cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb.regWrite  <= 1'b0;
      wb.regDest   <= '0;
      wb.writeData <= '0;
    end else if (wb.alu_valid) begin
      if (wb.alu_dest != 5'd0) begin
        wb.regWrite  <= 1'b1;
        wb.regDest   <= wb.alu_dest;
        wb.writeData <= wb.alu_data;
      end else begin
        wb.regWrite <= 1'b0;
      end
    end else if (popFifo) begin
      wb.regWrite  <= 1'b1;
      wb.regDest   <= destMem[rdPtr[AW-1:0]];
      wb.writeData <= dataMem[rdPtr[AW-1:0]];
    end else if (bypassTake) begin
      wb.regWrite  <= 1'b1;
      wb.regDest   <= wb.ll_dest;
      wb.writeData <= wb.ll_data;
    end else begin
      wb.regWrite <= 1'b0;
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  // Duplicate destinations OR together, so a bit stays set until the last one retires.
  always_comb begin
    logic [AW-1:0] slotOff;
    slotOff     = '0;
    pendingMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slotOff = AW'(i) - rdPtr[AW-1:0];
      if (PW'(slotOff) < count) pendingMask[destMem[i]] = 1'b1;
    end
    if (wb.regWrite) pendingMask[wb.regDest] = 1'b1;
    pendingMask[0] = 1'b0;
  end

  assign wb.pending_mask = pendingMask;
  assign wb.hazard_err   = wb.alu_valid && (wb.alu_dest != 5'd0) && pendingMask[wb.alu_dest];

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int EW    = 1 + 5 + WIDTH;

  logic clock;
  logic reset_n;

  regfile_writeback_if #(.WIDTH(WIDTH)) wb();

  regfile_writeback #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .wb     (wb)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];

  // Reference model: the long-latency queue and the state of the write port.
  typedef struct {
    logic [4:0]       d;
    logic [WIDTH-1:0] v;
  } ent_t;
  ent_t             mq[$];
  logic             m_wr;
  logic [4:0]       m_dest;
  logic [WIDTH-1:0] m_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    foreach (mq[i]) m[mq[i].d] = 1'b1;
    if (m_wr) m[m_dest] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_wr   = 1'b0;
    m_dest = '0;
    m_data = '0;
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs on negedge and checks the combinational outputs.
  // It then advances the model across the coming posedge and queues the
  // expected write-port state.
  task automatic step(input logic av, input logic [4:0] ad, input logic [WIDTH-1:0] adat,
                      input logic lv, input logic [4:0] ld, input logic [WIDTH-1:0] ldat,
                      output logic acc);
    logic [31:0] mask;
    logic        byp;
    ent_t        e;
    @(negedge clock);
    wb.alu_valid = av;
    wb.alu_dest  = ad;
    wb.alu_data  = adat;
    wb.ll_valid  = lv;
    wb.ll_dest   = ld;
    wb.ll_data   = ldat;
    #1;
    mask = model_mask();
    acc  = lv && (mq.size() < DEPTH);
    chk("ll_ready", wb.ll_ready, mq.size() < DEPTH);
    chk("pending_mask", wb.pending_mask, mask);
    chk("hazard_err", wb.hazard_err, av && (ad != 0) && mask[ad]);
    byp = 1'b0;
    if (av) begin
      if (ad != 0) begin
        m_wr = 1'b1; m_dest = ad; m_data = adat;
      end else begin
        m_wr = 1'b0;
      end
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_wr = 1'b1; m_dest = e.d; m_data = e.v;
    end
`ifdef WB_BYPASS_EN
    else if (acc && ld != 0) begin
      m_wr = 1'b1; m_dest = ld; m_data = ldat; byp = 1'b1;
    end
`endif
    else begin
      m_wr = 1'b0;
    end
    if (acc && ld != 0 && !byp) mq.push_back('{ld, ldat});
    exp_q.push_back({m_wr, m_dest, m_data});
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, a);
  endtask

  task automatic do_reset();
    @(negedge clock);
    wb.alu_valid = 1'b0;
    wb.ll_valid  = 1'b0;
    reset_n      = 1'b0;
    #1;
    chk("rst_regWrite", wb.regWrite, 0);
    chk("rst_regDest", wb.regDest, 0);
    chk("rst_writeData", wb.writeData, 0);
    chk("rst_pending_mask", wb.pending_mask, 0);
    chk("rst_ll_ready", wb.ll_ready, 1);
    chk("rst_hazard_err", wb.hazard_err, 0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("regWrite", wb.regWrite, e[EW-1]);
        chk("regDest", wb.regDest, e[WIDTH+4:WIDTH]);
        chk("writeData", wb.writeData, e[WIDTH-1:0]);
      end else begin
        chk("idle_regWrite", wb.regWrite, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic acc;
    int   k;
    int   guard;
    reset_n      = 1'b0;
    wb.alu_valid = 1'b0;
    wb.alu_dest  = '0;
    wb.alu_data  = '0;
    wb.ll_valid  = 1'b0;
    wb.ll_dest   = '0;
    wb.ll_data   = '0;
    model_reset();
    do_reset();

    // ALU only
    step(1'b1, 5'd5, 32'h0000_00AA, 1'b0, 5'd0, '0, acc);
    idle(2);

    // Collision: the ALU result goes first, then the long-latency result
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22, acc);
    idle(3);

    // Backpressure: continuous ALU traffic fills the FIFO
    k = 1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 5'(20 + i), $urandom, 1'b1, 5'(k), 32'h100 + k, acc);
      if (acc) k++;
    end
    guard = 0;
    while (k <= 5 && guard < 10) begin
      step(1'b0, 5'd0, '0, 1'b1, 5'(k), 32'h100 + k, acc);
      if (acc) k++;
      guard++;
    end
    chk("backpressure_all_accepted", k, 6);
    idle(6);

    // x0 drop on both paths
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'h5555_5555, acc);
    idle(3);

    // Hazard: queue r9, then an ALU write to r9
    step(1'b0, 5'd0, '0, 1'b1, 5'd9, 32'h99, acc);
    step(1'b1, 5'd9, 32'h1234, 1'b0, 5'd0, '0, acc);
    idle(3);

    // Reset mid-operation with three queued entries
    for (int i = 0; i < 3; i++) step(1'b1, 5'(24 + i), $urandom, 1'b1, 5'(12 + i), $urandom, acc);
    do_reset();
    idle(5);

    // Isolated long-latency result
    step(1'b0, 5'd0, '0, 1'b1, 5'd4, 32'h44, acc);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom, acc);
    end

    guard = 0;
    while (mq.size() > 0 && guard < 20) begin
      idle(1);
      guard++;
    end
    idle(2);
    @(posedge clock);
    #2;
    chk("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-back initiator for the 32x32 register file. It merges results from the single-cycle ALU path and a long-latency unit (load/multiply) into one registered write port: regWrite, regDest, writeData.
- ALU results always win the port. Long-latency results are buffered in a small FIFO.
- Publishes a pending-destination mask so the issue stage can stall on hazards.
- Outputs change on posedge clock only, so they are stable at the register file's negedge write.

Parameters:
- DEPTH, 4, long-latency FIFO entries (power of 2, >=2).
- WIDTH, 32, data width.

Ports:
- clock  in  1  system clock, posedge.
- reset_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result present this cycle (no backpressure).
- alu_dest  in  5  ALU destination register.
- alu_data  in  WIDTH  ALU result.
- ll_valid  in  1  long-latency result offered.
- ll_ready  out  1  FIFO can accept; transfer occurs when ll_valid & ll_ready at posedge.
- ll_dest  in  5  long-latency destination register.
- ll_data  in  WIDTH  long-latency result.
- regWrite  out  1  write strobe to the register file.
- regDest  out  5  write address.
- writeData  out  WIDTH  write data.
- pending_mask  out  32  bit r=1 while a write to r is queued or held in the output register.
- hazard_err  out  1  one-cycle pulse: alu_valid while pending_mask[alu_dest]=1 (alu_dest!=0).

Behaviour:
- Reset (async, reset_n=0): regWrite=0, regDest=0, writeData=0, FIFO empty, ll_ready=1, pending_mask=0, hazard_err=0. Deassertion takes effect at the next posedge.
- Reset mid-operation: all queued writes are discarded and none reach the register file.
- Output register, each posedge:
  - If alu_valid=1: load ALU result.
  - Else if FIFO non-empty: pop head and load it.
  - Else: regWrite=0. regDest and writeData hold their previous values.
- x0 filter: any result with dest=0 is dropped at entry. The ALU result does not load the output register. The long-latency handshake still completes, but nothing is pushed. regWrite is never asserted with regDest=0.
- Latency:
  - ALU sampled at edge N -> regWrite=1 during cycle after edge N.
  - Long-latency accepted at edge N -> earliest regWrite during cycle after edge N+1 (one FIFO cycle).
  - Each additional ALU-valid cycle delays pops by one cycle.
- FIFO:
  - Read/write pointers are log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH.
  - full = MSBs differ and low bits equal. ll_ready = !full, derived from registered pointers only.
  - When full, no push occurs even if a pop happens in the same cycle; ll_ready returns 1 the cycle after the pop.
  - Push and pop in the same cycle when not full or empty: count unchanged, order preserved.
  - Pop from empty never occurs.
- Ordering: FIFO entries retire in acceptance order. ALU writes may overtake queued long-latency writes.
  - The issue stage must not issue an ALU op whose dest is set in pending_mask.
  - hazard_err flags violations. It is combinational from alu_valid, alu_dest and pending_mask, and never alters data flow.
- pending_mask:
  - Combinational OR over valid FIFO entries' dest, plus regDest when regWrite=1.
  - Bit 0 is always 0.
  - Multiple entries to the same register keep the bit set until the last one retires.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: when alu_valid=0, FIFO empty, and ll_valid & ll_ready with ll_dest!=0, the long-latency result loads the output register directly at the same edge. No push occurs. Latency is one cycle, matching the ALU path.
- Undefined: every long-latency result passes through the FIFO, with fixed two-cycle minimum latency.
- All other behaviour is identical.

Test Plan:
- ALU only: alu_valid=1, dest=5, data=0x0000_00AA at edge N -> regWrite=1, regDest=5, writeData=0xAA in cycle N+1. regWrite=0 in cycle N+2.
- Collision: same edge alu(dest=3, 0x11) and ll(dest=7, 0x22) -> cycle N+1 writes r3=0x11; cycle N+2 writes r7=0x22. pending_mask[7]=1 from N+1 until end of N+2.
- Backpressure: alu_valid=1 continuously, offer 5 ll results to dests 1..5, DEPTH=4 -> ll_ready=0 after 4th accept. Drop alu_valid -> writes r1,r2,r3,r4,r5 in order on consecutive cycles. ll_ready=1 the cycle after the first pop.
- x0 drop: alu dest=0 data=0xFFFF_FFFF, and ll dest=0 accepted -> regWrite stays 0, FIFO count stays 0, pending_mask=0.
- Hazard: queue ll dest=9, then alu_valid dest=9 -> hazard_err=1 for exactly that cycle. Both writes still performed, ALU first.
- Reset mid-operation: FIFO holding 3 entries, drive reset_n=0 between edges -> regWrite=0 immediately, pending_mask=0. After release, no queued write appears. With WB_BYPASS_EN, an isolated ll result (dest=4, 0x44) at edge N -> r4 written in cycle N+1.
